// File: rtl/adder_carry_pkg.sv
// Shared constants for the pipelined carry-chain adder.
package adder_carry_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned DEFAULT_WIDTH  = 8;
    localparam int unsigned DEFAULT_STAGES = 2;

endpackage

// File: rtl/adder_carry_segment.sv
// Combinational ripple-carry segment built from propagate/generate terms.
module adder_carry_segment #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a_i,
    input  logic [SEG-1:0] b_i,
    input  logic           ci_i,
    output logic [SEG-1:0] sum_o,
    output logic           co_o,
    output logic           cmsb_o
);

    logic [SEG:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = ci_i;
        for (int unsigned i = 0; i < SEG; i++) begin
            sum_o[i] = (a_i[i] ^ b_i[i]) ^ c[i];
            c[i+1]   = (a_i[i] ^ b_i[i]) ? c[i] : (a_i[i] & b_i[i]);
        end
    end

    assign co_o   = c[SEG];
    assign cmsb_o = c[SEG-1];

endmodule

// File: rtl/adder_carry_chain_pipe.sv
// Add/subtract unit whose carry chain is cut into STAGES registered segments,
// with a valid/ready handshake and a single global advance enable.
module adder_carry_chain_pipe
    import adder_carry_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] adder_carry_a,
    input  logic [WIDTH-1:0] adder_carry_b,
    input  logic             adder_carry_cin,
    input  logic             adder_carry_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] adder_carry_sumout,
    output logic             adder_carry_cout,
    output logic             adder_carry_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SDIV = (STAGES == 0) ? 1 : STAGES;
    localparam int unsigned SEG  = WIDTH / SDIV;
    localparam int unsigned LAST = SDIV - 1;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % SDIV) != 0) begin : g_param_check
        $error("adder_carry_chain_pipe: illegal WIDTH/STAGES combination");
    end

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SEG;

        logic             valid_s, op_s, ci_s;
        logic [WIDTH-1:LO] a_s, b_s;
        logic [WIDTH-1:0] sum_s, sum_d, sum_q;
        logic [SEG-1:0]   bx_seg, seg_sum;
        logic             seg_co, seg_cmsb;
        logic             valid_q, carry_q;

        if (k == 0) begin : g_src
            assign valid_s = in_valid;
            assign op_s    = adder_carry_op;
            assign ci_s    = (adder_carry_op == OP_SUB) ? 1'b1 : adder_carry_cin;
            assign a_s     = adder_carry_a;
            assign b_s     = adder_carry_b;
            assign sum_s   = '0;
        end else begin : g_src
            assign valid_s = g_stage[k-1].valid_q;
            assign op_s    = g_stage[k-1].g_fwd.op_q;
            assign ci_s    = g_stage[k-1].carry_q;
            assign a_s     = g_stage[k-1].g_fwd.a_q;
            assign b_s     = g_stage[k-1].g_fwd.b_q;
            assign sum_s   = g_stage[k-1].sum_q;
        end

        assign bx_seg = b_s[LO +: SEG] ^ {SEG{op_s == OP_SUB}};

        adder_carry_segment #(
            .SEG(SEG)
        ) u_seg (
            .a_i   (a_s[LO +: SEG]),
            .b_i   (bx_seg),
            .ci_i  (ci_s),
            .sum_o (seg_sum),
            .co_o  (seg_co),
            .cmsb_o(seg_cmsb)
        );

        always_comb begin
            sum_d             = sum_s;
            sum_d[LO +: SEG]  = seg_sum;
        end

        always_ff @(posedge clk) begin
            if (!resetb) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (en) begin
                valid_q <= valid_s;
                carry_q <= seg_co;
                sum_q   <= sum_d;
            end
        end

        // Only the bits not yet consumed by a segment travel forward.
        if (k < LAST) begin : g_fwd
            logic                       op_q;
            logic [WIDTH-1:LO+SEG] a_q, b_q;
            logic                       unused_cmsb;

            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk) begin
                if (en) begin
                    op_q <= op_s;
                    a_q  <= a_s[WIDTH-1:LO+SEG];
                    b_q  <= b_s[WIDTH-1:LO+SEG];
                end
            end
        end else begin : g_tail
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!resetb) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= seg_cmsb ^ seg_co;
                end
            end
        end
    end

    assign out_valid          = g_stage[LAST].valid_q;
    assign adder_carry_sumout = g_stage[LAST].sum_q;
    assign adder_carry_cout   = g_stage[LAST].carry_q;
    assign adder_carry_ovf    = g_stage[LAST].g_tail.ovf_q;

endmodule

// File: tb/tb_adder_carry_chain_pipe.sv
// Scoreboard bench: directed 8-bit vectors with stalls and reset, plus
// randomized 16-bit runs at one and four stages against a reference model.
module tb_adder_carry_chain_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb;

    logic [7:0]  a8, b8, sum8;
    logic        cin8, op8, iv8, ir8, ov8, or8, cout8, ovf8;

    logic [15:0] a16, b16, sum1, sum4;
    logic        cin16, op16, iv16, or16;
    logic        ir1, ov1, cout1, ovf1;
    logic        ir4, ov4, cout4, ovf4;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  exp8_q[$];
    int          lat8_q[$];
    logic [17:0] exp1_q[$], exp4_q[$];
    int          acc1_q[$], acc4_q[$];

    typedef struct {
        logic       op;
        logic       cin;
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] exp;   // {ovf, cout, sum}
    } vec_t;

    vec_t vecs [12];

    adder_carry_chain_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .resetb(resetb),
        .adder_carry_a(a8), .adder_carry_b(b8), .adder_carry_cin(cin8), .adder_carry_op(op8),
        .in_valid(iv8), .in_ready(ir8),
        .adder_carry_sumout(sum8), .adder_carry_cout(cout8), .adder_carry_ovf(ovf8),
        .out_valid(ov8), .out_ready(or8)
    );

    adder_carry_chain_pipe #(.WIDTH(16), .STAGES(1)) u_dut16s1 (
        .clk(clk), .resetb(resetb),
        .adder_carry_a(a16), .adder_carry_b(b16), .adder_carry_cin(cin16), .adder_carry_op(op16),
        .in_valid(iv16), .in_ready(ir1),
        .adder_carry_sumout(sum1), .adder_carry_cout(cout1), .adder_carry_ovf(ovf1),
        .out_valid(ov1), .out_ready(or16)
    );

    adder_carry_chain_pipe #(.WIDTH(16), .STAGES(4)) u_dut16s4 (
        .clk(clk), .resetb(resetb),
        .adder_carry_a(a16), .adder_carry_b(b16), .adder_carry_cin(cin16), .adder_carry_op(op16),
        .in_valid(iv16), .in_ready(ir4),
        .adder_carry_sumout(sum4), .adder_carry_cout(cout4), .adder_carry_ovf(ovf4),
        .out_valid(ov4), .out_ready(or16)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [17:0] model16(input logic op, input logic cin,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bb;
        logic [16:0] s;
        logic        v;
        bb = op ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {16'd0, (op ? 1'b1 : cin)};
        v  = (a[15] == bb[15]) && (s[15] != a[15]);
        return {v, s[16], s[15:0]};
    endfunction

    // Monitors: peek at the head every cycle out_valid is high, pop on handshake.
    always @(negedge clk) begin
        if (ov8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                checks++;
                $display("FAIL dut8_unexpected_output got=%h exp=none", {ovf8, cout8, sum8});
            end else begin
                check("dut8_result", 32'({ovf8, cout8, sum8}), 32'(exp8_q[0]));
                if (lat8_q[0] >= 0) begin
                    check("dut8_latency", 32'(cyc - lat8_q[0]), 32'd2);
                    lat8_q[0] = -1;
                end
                if (or8) begin
                    void'(exp8_q.pop_front());
                    void'(lat8_q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                $display("FAIL dut16s1_unexpected_output got=%h exp=none", {ovf1, cout1, sum1});
            end else begin
                check("dut16s1_result", 32'({ovf1, cout1, sum1}), 32'(exp1_q[0]));
                check("dut16s1_latency", 32'(cyc - acc1_q[0]), 32'd1);
                void'(exp1_q.pop_front());
                void'(acc1_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (ov4 === 1'b1) begin
            if (exp4_q.size() == 0) begin
                checks++;
                $display("FAIL dut16s4_unexpected_output got=%h exp=none", {ovf4, cout4, sum4});
            end else begin
                check("dut16s4_result", 32'({ovf4, cout4, sum4}), 32'(exp4_q[0]));
                check("dut16s4_latency", 32'(cyc - acc4_q[0]), 32'd4);
                void'(exp4_q.pop_front());
                void'(acc4_q.pop_front());
            end
        end
    end

    task automatic send8(input int idx, input bit chk_lat);
        int unsigned n;
        bit          acc;
        n   = 0;
        acc = 1'b0;
        op8 = vecs[idx].op;
        cin8 = vecs[idx].cin;
        a8  = vecs[idx].a;
        b8  = vecs[idx].b;
        iv8 = 1'b1;
        while (!acc && n < 40) begin
            @(negedge clk);
            if (ir8 === 1'b1) begin
                acc = 1'b1;
                exp8_q.push_back(vecs[idx].exp);
                lat8_q.push_back(chk_lat ? cyc : -1);
            end
            @(posedge clk);
            #1;
            n++;
        end
        iv8 = 1'b0;
        if (!acc) begin
            checks++;
            $display("FAIL send8_accept_timeout vec=%0d got=no_accept exp=accept", idx);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp8_q.size() + exp1_q.size() + exp4_q.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int issued;
        int guard;

        //          op    cin   a      b      {ovf,cout,sum}
        vecs[0]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 10'h100};
        vecs[1]  = '{1'b1, 1'b0, 8'h10, 8'h01, 10'h10F};
        vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h01, 10'h0FF};
        vecs[3]  = '{1'b0, 1'b0, 8'h7F, 8'h01, 10'h280};
        vecs[4]  = '{1'b0, 1'b1, 8'h12, 8'h34, 10'h047};
        vecs[5]  = '{1'b1, 1'b0, 8'h80, 8'h01, 10'h37F};
        vecs[6]  = '{1'b1, 1'b1, 8'h05, 8'h05, 10'h100};
        vecs[7]  = '{1'b0, 1'b0, 8'h80, 8'h80, 10'h300};
        vecs[8]  = '{1'b0, 1'b1, 8'hA5, 8'h5A, 10'h100};
        vecs[9]  = '{1'b1, 1'b0, 8'h3C, 8'hC3, 10'h079};
        vecs[10] = '{1'b0, 1'b0, 8'h40, 8'h40, 10'h280};
        vecs[11] = '{1'b1, 1'b0, 8'h7F, 8'hFF, 10'h280};

        resetb = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; op16 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(ov8), 32'd0);
        check("reset_in_ready", 32'(ir8), 32'd1);
        check("reset_sumout", 32'(sum8), 32'd0);
        check("reset_cout", 32'(cout8), 32'd0);
        check("reset_ovf", 32'(ovf8), 32'd0);
        @(posedge clk);
        #1 resetb = 1'b1;

        // Directed vectors back-to-back with latency checking.
        for (int i = 0; i < 12; i++) send8(i, 1'b1);
        drain();

        // Five back-to-back transactions with a three-cycle output stall.
        fork
            begin
                for (int i = 4; i < 9; i++) send8(i, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 or8 = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("in_ready_during_stall", 32'(ir8), 32'd0);
                    @(posedge clk);
                    #1;
                end
                or8 = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight; inputs driven during reset.
        or8 = 1'b0;
        send8(9, 1'b0);
        send8(10, 1'b0);
        resetb = 1'b0;
        iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; op8 = 1'b0; cin8 = 1'b0;
        @(posedge clk);
        #1;
        exp8_q.delete();
        lat8_q.delete();
        resetb = 1'b1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 32'(ov8), 32'd0);
        check("midreset_in_ready", 32'(ir8), 32'd1);
        check("midreset_sumout", 32'(sum8), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        send8(11, 1'b1);
        drain();

        // Randomized 16-bit operations with bubbles.
        issued = 0;
        guard  = 0;
        while (issued < 1000 && guard < 5000) begin
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            op16  = 1'($urandom_range(0, 1));
            cin16 = 1'($urandom_range(0, 1));
            iv16  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (iv16) begin
                if (ir1 === 1'b1) begin
                    exp1_q.push_back(model16(op16, cin16, a16, b16));
                    acc1_q.push_back(cyc);
                end
                if (ir4 === 1'b1) begin
                    exp4_q.push_back(model16(op16, cin16, a16, b16));
                    acc4_q.push_back(cyc);
                end
                issued++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        iv16 = 1'b0;
        drain();

        check("dut8_queue_empty", 32'(exp8_q.size()), 32'd0);
        check("dut16s1_queue_empty", 32'(exp1_q.size()), 32'd0);
        check("dut16s4_queue_empty", 32'(exp4_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
